// File: rtl/serial_alu.sv
// Digit-serial integer ALU: processes DIGIT bits per clock, LSB digit first,
// under a start/busy/done handshake. Supports add, sub, AND, OR and signed slt.
module serial_alu #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal_op
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [WIDTH-1:0]      r_a;
    logic [WIDTH-1:0]      r_b;
    logic [3:0]            r_op;
    logic                  r_carry;
    logic [CW-1:0]         r_count;
    logic [WIDTH-DIGIT-1:0] r_acc;

    logic                  w_subtract;
    logic                  w_legal;
    logic [DIGIT-1:0]      w_bDigit;
    logic [DIGIT:0]        w_sum;
    logic [DIGIT-1:0]      w_digit;
    logic                  w_carryIntoMsb;
    logic                  w_less;
    logic [WIDTH-1:0]      w_final;
    logic [WIDTH-1:0]      w_result;
    logic                  w_lastDigit;

    assign w_subtract = (r_op == OP_SUB) || (r_op == OP_SLT);
    assign w_bDigit   = w_subtract ? ~r_b[DIGIT-1:0] : r_b[DIGIT-1:0];
    assign w_sum      = {1'b0, r_a[DIGIT-1:0]} + {1'b0, w_bDigit} + {{DIGIT{1'b0}}, r_carry};

    // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ cin.
    assign w_carryIntoMsb = w_sum[DIGIT-1] ^ r_a[DIGIT-1] ^ w_bDigit[DIGIT-1];
    assign w_less         = w_sum[DIGIT-1] ^ (w_carryIntoMsb ^ w_sum[DIGIT]);

    assign w_final     = {w_digit, r_acc};
    assign w_lastDigit = (r_count == CW'(N - 1));

    always_comb begin
        w_digit  = w_sum[DIGIT-1:0];
        w_legal  = 1'b1;
        w_result = w_final;
        case (r_op)
            OP_AND: w_digit = r_a[DIGIT-1:0] & r_b[DIGIT-1:0];
            OP_OR:  w_digit = r_a[DIGIT-1:0] | r_b[DIGIT-1:0];
            OP_ADD, OP_SUB: w_result = w_final;
            OP_SLT: w_result = {{(WIDTH-1){1'b0}}, w_less};
            default: begin
                w_legal  = 1'b0;
                w_result = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_carry    <= 1'b0;
            r_count    <= '0;
            r_acc      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            zero       <= 1'b1;
            illegal_op <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= operation;
                        r_carry <= (operation == OP_SUB) || (operation == OP_SLT);
                        r_count <= '0;
                        r_acc   <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_sum[DIGIT];
                    r_acc   <= w_final[WIDTH-1:DIGIT];
                    r_count <= r_count + 1'b1;
                    if (w_lastDigit) begin
                        r_state    <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        result     <= w_result;
                        zero       <= (w_result == '0);
                        illegal_op <= !w_legal;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
// Directed self-checking bench for serial_alu (WIDTH=32, DIGIT=4, eight RUN cycles).
module tb_serial_alu;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [3:0]  operation;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic        illegal_op;

    int passCount;
    int totalCount;

    serial_alu #(.WIDTH(32), .DIGIT(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .operation  (operation),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .zero       (zero),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive start for exactly one edge; returns 1 ns after the accepting edge.
    task automatic startOp(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
        operation = op;
        a         = va;
        b         = vb;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
    endtask

    // Waits for done with a bound; reports edges taken and busy samples seen.
    task automatic waitDone(output int cycles, output int busyCycles, output bit seen);
        cycles     = 0;
        busyCycles = 0;
        seen       = 1'b0;
        while (cycles < 20 && !seen) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) seen = 1'b1;
            else if (busy) busyCycles++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        totalCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else passCount++;
        totalCount++; if (done !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", done); else passCount++;
        totalCount++; if (result !== 32'h0) $display("[TB] FAIL reset_result got %h want 0", result); else passCount++;
        totalCount++; if (zero !== 1'b1) $display("[TB] FAIL reset_zero got %b want 1", zero); else passCount++;
        totalCount++; if (illegal_op !== 1'b0) $display("[TB] FAIL reset_illegal got %b want 0", illegal_op); else passCount++;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add;
        int cyc; int bc; bit seen;
        startOp(OP_ADD, 32'h5, 32'h3);
        totalCount++; if (busy !== 1'b1) $display("[TB] FAIL add_busy_first got %b want 1", busy); else passCount++;
        waitDone(cyc, bc, seen);
        totalCount++; if (!seen || cyc != 8) $display("[TB] FAIL add_latency got %0d seen=%0d want 8", cyc, seen); else passCount++;
        totalCount++; if (bc != 7) $display("[TB] FAIL add_busy_cycles got %0d want 7", bc); else passCount++;
        totalCount++; if (busy !== 1'b0) $display("[TB] FAIL add_busy_in_done got %b want 0", busy); else passCount++;
        totalCount++; if (result !== 32'h8) $display("[TB] FAIL add_result got %h want 00000008", result); else passCount++;
        totalCount++; if (zero !== 1'b0) $display("[TB] FAIL add_zero got %b want 0", zero); else passCount++;
        totalCount++; if (illegal_op !== 1'b0) $display("[TB] FAIL add_illegal got %b want 0", illegal_op); else passCount++;
        @(posedge clk);
        #1;
        totalCount++; if (done !== 1'b0) $display("[TB] FAIL add_done_pulse got %b want 0", done); else passCount++;
    endtask

    task automatic test_carry;
        logic [3:0]  ops [3]  = '{OP_ADD, OP_SUB, OP_SUB};
        logic [31:0] va  [3]  = '{32'h0000_FFFF, 32'h5, 32'h0};
        logic [31:0] vb  [3]  = '{32'h0000_0001, 32'h5, 32'h1};
        logic [31:0] exp [3]  = '{32'h0001_0000, 32'h0, 32'hFFFF_FFFF};
        int cyc; int bc; bit seen;
        for (int i = 0; i < 3; i++) begin
            startOp(ops[i], va[i], vb[i]);
            waitDone(cyc, bc, seen);
            totalCount++; if (!seen || result !== exp[i]) $display("[TB] FAIL carry_result[%0d] got %h want %h", i, result, exp[i]); else passCount++;
            totalCount++; if (zero !== (exp[i] == 32'h0)) $display("[TB] FAIL carry_zero[%0d] got %b want %b", i, zero, exp[i] == 32'h0); else passCount++;
        end
    endtask

    task automatic test_slt;
        logic [31:0] va  [4] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h3};
        logic [31:0] vb  [4] = '{32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFF, 32'h3};
        logic [31:0] exp [4] = '{32'h1, 32'h0, 32'h1, 32'h0};
        int cyc; int bc; bit seen;
        for (int i = 0; i < 4; i++) begin
            startOp(OP_SLT, va[i], vb[i]);
            waitDone(cyc, bc, seen);
            totalCount++; if (!seen || result !== exp[i]) $display("[TB] FAIL slt_result[%0d] got %h want %h", i, result, exp[i]); else passCount++;
        end
        totalCount++; if (zero !== 1'b1) $display("[TB] FAIL slt_equal_zero got %b want 1", zero); else passCount++;
    endtask

    task automatic test_back_to_back;
        int cyc; int bc; bit seen;
        startOp(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        waitDone(cyc, bc, seen);
        totalCount++; if (!seen || result !== 32'hF000_F000) $display("[TB] FAIL b2b_and got %h want F000F000", result); else passCount++;
        startOp(OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00);
        totalCount++; if (busy !== 1'b1 || done !== 1'b0) $display("[TB] FAIL b2b_accept got busy=%b done=%b want busy=1 done=0", busy, done); else passCount++;
        totalCount++; if (result !== 32'hF000_F000) $display("[TB] FAIL b2b_hold got %h want F000F000", result); else passCount++;
        waitDone(cyc, bc, seen);
        totalCount++; if (!seen || cyc != 8) $display("[TB] FAIL b2b_spacing got %0d want 8 after accept edge", cyc); else passCount++;
        totalCount++; if (result !== 32'hFFF0_FFF0) $display("[TB] FAIL b2b_or got %h want FFF0FFF0", result); else passCount++;
    endtask

    task automatic test_illegal;
        int cyc; int bc; bit seen;
        startOp(4'b0101, 32'h1234_5678, 32'h0000_0001);
        waitDone(cyc, bc, seen);
        totalCount++; if (!seen || cyc != 8) $display("[TB] FAIL illegal_latency got %0d want 8", cyc); else passCount++;
        totalCount++; if (result !== 32'h0 || zero !== 1'b1) $display("[TB] FAIL illegal_result got %h zero=%b want 0 zero=1", result, zero); else passCount++;
        totalCount++; if (illegal_op !== 1'b1) $display("[TB] FAIL illegal_flag got %b want 1", illegal_op); else passCount++;
        startOp(OP_ADD, 32'h1, 32'h2);
        totalCount++; if (illegal_op !== 1'b1) $display("[TB] FAIL illegal_hold got %b want 1", illegal_op); else passCount++;
        waitDone(cyc, bc, seen);
        totalCount++; if (!seen || illegal_op !== 1'b0 || result !== 32'h3) $display("[TB] FAIL illegal_clear got ill=%b res=%h want 0 00000003", illegal_op, result); else passCount++;
    endtask

    task automatic test_ignore_start;
        int cyc; int bc; bit seen;
        startOp(OP_ADD, 32'd10, 32'd20);
        repeat (3) @(posedge clk);
        #1;
        startOp(OP_SUB, 32'hAAAA_AAAA, 32'h1111_1111);
        totalCount++; if (result !== 32'h3) $display("[TB] FAIL ignore_partial got %h want 00000003", result); else passCount++;
        waitDone(cyc, bc, seen);
        totalCount++; if (!seen || cyc != 4) $display("[TB] FAIL ignore_latency got %0d want 4", cyc); else passCount++;
        totalCount++; if (result !== 32'd30) $display("[TB] FAIL ignore_result got %h want 0000001e", result); else passCount++;
    endtask

    task automatic test_reset_run;
        int cyc; int bc; bit seen;
        bit doneSeen;
        startOp(OP_ADD, 32'd7, 32'd8);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        totalCount++; if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL rrun_abort got busy=%b done=%b want 0 0", busy, done); else passCount++;
        totalCount++; if (result !== 32'h0 || zero !== 1'b1) $display("[TB] FAIL rrun_result got %h zero=%b want 0 zero=1", result, zero); else passCount++;
        doneSeen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) doneSeen = 1'b1;
        end
        totalCount++; if (doneSeen) $display("[TB] FAIL rrun_no_done got pulse want none"); else passCount++;
        startOp(OP_SUB, 32'd9, 32'd4);
        waitDone(cyc, bc, seen);
        totalCount++; if (!seen || cyc != 8 || result !== 32'd5) $display("[TB] FAIL rrun_fresh got cyc=%0d res=%h want 8 00000005", cyc, result); else passCount++;
    endtask

    initial begin
        passCount  = 0;
        totalCount = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        operation  = 4'b0;
        a          = '0;
        b          = '0;
        test_reset();
        test_add();
        test_carry();
        test_slt();
        test_back_to_back();
        test_illegal();
        test_ignore_start();
        test_reset_run();
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
